serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_if.sv | 30 +++
 rtl/serial_add_ctrl.sv | 106 ++++++++++
 tb/tb_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Bundle of the operand/result handshake and the single shared full_adder hookup
// used by serial_add_ctrl.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_y;
    logic             fa_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    // master: requester plus the external full_adder returning Y/Cout
    modport master (
        output start, a, b, cin, fa_y, fa_cout,
        input  fa_a, fa_b, fa_cin, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin, fa_y, fa_cout,
        output fa_a, fa_b, fa_cin, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external full_adder across WIDTH cycles,
// LSB first, and reports {cout,sum} with a one-cycle done pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 5
) (
    input  logic             clk,
    input  logic             reset,
    serial_add_ctrl_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_a, fa_b, fa_cin, busy, done;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        fa_a     = 1'b0;
        fa_b     = 1'b0;
        fa_cin   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    a_sh_d   = bus_io.a;
                    b_sh_d   = bus_io.b;
                    carry_d  = bus_io.cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                busy     = 1'b1;
                fa_a     = a_sh_q[0];
                fa_b     = b_sh_q[0];
                fa_cin   = carry_q;
                sum_sh_d = sum_sh_q >> 1;
                sum_sh_d[WIDTH-1] = bus_io.fa_y;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = bus_io.fa_cout;
                cnt_d    = cnt_q + CW'(1);
                // Last bit: publish the result on the same edge that enters DONE
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = sum_sh_d;
                    cout_d  = bus_io.fa_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus_io.fa_a   = fa_a;
    assign bus_io.fa_b   = fa_b;
    assign bus_io.fa_cin = fa_cin;
    assign bus_io.busy   = busy;
    assign bus_io.done   = done;
    assign bus_io.sum    = sum_q;
    assign bus_io.cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a WIDTH=4 and a WIDTH=1 instance, each wired to
// a behavioural full adder, checked against {cout,sum} = a + b + cin.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(4)) bus4 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(4), .CW(5)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus4)
    );

    serial_add_ctrl #(.WIDTH(1), .CW(5)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus1)
    );

    // External full adders
    assign bus4.fa_y    = bus4.fa_a ^ bus4.fa_b ^ bus4.fa_cin;
    assign bus4.fa_cout = (bus4.fa_a & bus4.fa_b) | (bus4.fa_cin & (bus4.fa_a ^ bus4.fa_b));
    assign bus1.fa_y    = bus1.fa_a ^ bus1.fa_b ^ bus1.fa_cin;
    assign bus1.fa_cout = (bus1.fa_a & bus1.fa_b) | (bus1.fa_cin & (bus1.fa_a ^ bus1.fa_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c);
        int         n;
        int         nbusy;
        logic [3:0] seq_a;
        logic [3:0] seq_b;
        logic [4:0] exp;
        exp   = 5'(a) + 5'(b) + 5'(c);
        seq_a = '0;
        seq_b = '0;
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = c;
        tick();
        // Post-acceptance operand changes must be ignored
        bus4.start = 1'b0;
        bus4.a     = 4'($urandom);
        bus4.b     = 4'($urandom);
        bus4.cin   = 1'($urandom);
        n     = 0;
        nbusy = 0;
        while (bus4.done !== 1'b1 && n < 50) begin
            if (bus4.busy === 1'b1 && nbusy < 4) begin
                seq_a[nbusy] = bus4.fa_a;
                seq_b[nbusy] = bus4.fa_b;
                nbusy++;
            end
            tick();
            n++;
        end
        chk("w4_latency", 32'(n), 32'd4);
        chk("w4_busy_cycles", 32'(nbusy), 32'd4);
        chk("w4_fa_a_seq", 32'(seq_a), 32'(a));
        chk("w4_fa_b_seq", 32'(seq_b), 32'(b));
        chk("w4_sum", 32'(bus4.sum), 32'(exp[3:0]));
        chk("w4_cout", 32'(bus4.cout), 32'(exp[4]));
        chk("w4_busy_at_done", 32'(bus4.busy), 32'd0);
        tick();
        chk("w4_done_pulse", 32'(bus4.done), 32'd0);
        chk("w4_fa_idle", 32'({bus4.fa_a, bus4.fa_b, bus4.fa_cin}), 32'd0);
    endtask

    task automatic run1(input logic a, input logic b, input logic c);
        int         n;
        logic [1:0] exp;
        exp = 2'(a) + 2'(b) + 2'(c);
        bus1.start = 1'b1;
        bus1.a     = a;
        bus1.b     = b;
        bus1.cin   = c;
        tick();
        bus1.start = 1'b0;
        n = 0;
        while (bus1.done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("w1_latency", 32'(n), 32'd1);
        chk("w1_sum", 32'(bus1.sum), 32'(exp[0]));
        chk("w1_cout", 32'(bus1.cout), 32'(exp[1]));
        tick();
        chk("w1_done_pulse", 32'(bus1.done), 32'd0);
    endtask

    initial begin
        int done_at[$];
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_done", 32'(bus4.done), 32'd0);
        chk("rst_sum", 32'(bus4.sum), 32'd0);
        chk("rst_cout", 32'(bus4.cout), 32'd0);
        chk("rst_fa", 32'({bus4.fa_a, bus4.fa_b, bus4.fa_cin}), 32'd0);
        chk("rst_w1_sum", 32'({bus1.cout, bus1.sum, bus1.busy, bus1.done}), 32'd0);
        reset = 1'b0;
        tick();

        // Directed cases
        run4(4'd5, 4'd6, 1'b0);
        run4(4'd15, 4'd1, 1'b0);
        run4(4'd7, 4'd8, 1'b1);

        // Start held high: accepted only in IDLE, mid-run operand changes ignored
        for (int c = 0; c < 18; c++) begin
            bus4.start = 1'b1;
            if ((c % 6) >= 1 && (c % 6) <= 3) begin
                bus4.a = 4'($urandom);
                bus4.b = 4'($urandom);
            end else begin
                bus4.a = 4'd3;
                bus4.b = 4'd4;
            end
            bus4.cin = 1'b0;
            tick();
            if (bus4.done === 1'b1) begin
                done_at.push_back(c);
                chk("held_sum", 32'(bus4.sum), 32'd7);
                chk("held_cout", 32'(bus4.cout), 32'd0);
            end
        end
        bus4.start = 1'b0;
        tick();
        chk("held_done_count", 32'(done_at.size()), 32'd3);
        for (int i = 1; i < done_at.size(); i++)
            chk("held_done_period", 32'(done_at[i] - done_at[i-1]), 32'd6);

        // Reset in the second RUN cycle aborts without a done pulse
        bus4.start = 1'b1; bus4.a = 4'd9; bus4.b = 4'd9; bus4.cin = 1'b0;
        tick();
        bus4.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_sum", 32'(bus4.sum), 32'd0);
        chk("abort_cout", 32'(bus4.cout), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_done", 32'(bus4.done), 32'd0);
            tick();
        end
        run4(4'd2, 4'd3, 1'b0);

        // Result held through idle; then reset+start together
        run4(4'd5, 4'd6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hold_sum", 32'({bus4.cout, bus4.sum}), 32'd11);
        end
        reset = 1'b1;
        bus4.start = 1'b1; bus4.a = 4'd12; bus4.b = 4'd13;
        tick();
        reset = 1'b0;
        bus4.start = 1'b0;
        chk("rst_start_busy", 32'(bus4.busy), 32'd0);
        chk("rst_start_out", 32'({bus4.done, bus4.cout, bus4.sum}), 32'd0);
        tick();
        chk("rst_start_idle", 32'({bus4.busy, bus4.done}), 32'd0);

        // WIDTH=1 instance
        run1(1'b1, 1'b1, 1'b1);
        for (int v = 0; v < 8; v++) run1(v[2], v[1], v[0]);

        // Random operands, then exhaustive sweep
        for (int i = 0; i < 20; i++) run4(4'($urandom), 4'($urandom), 1'($urandom));
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run4(4'(a), 4'(b), 1'(c));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
